// File: rtl/mux4_pkg.sv
// Shared constants, FSM state type and pointer helper for the 4-to-1 round-robin merge mux.
package mux4_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Lane after g, wrapping so the lane just served drops to lowest priority.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
    return SEL_W'((int'(g) + 1) % CH_NUM);
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational rotating-priority arbiter: first requester found scanning ptr, ptr+1, ... wins.
module rr_arbiter_4
  import mux4_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [CH_NUM-1:0] gnt,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  logic             found;
  logic [SEL_W-1:0] lane;

  // any/idx reflect the scan alone; en only gates the one-hot grant.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    lane  = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      lane = ptr + SEL_W'(k);
      if (!found && req[lane]) begin
        found = 1'b1;
        idx   = lane;
      end
    end
    any = found;
    gnt = '0;
    if (en && found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_4to1_rr.sv
// Registered 4-to-1 round-robin merge mux with source-lane tag.
// Optional per-lane saturating grant counters when MUX4_GRANT_CNT_EN is defined.
module mux_4to1_rr
  import mux4_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef MUX4_GRANT_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        in_valid,
  output logic [CH_NUM-1:0]        in_ready,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     busy
`ifdef MUX4_GRANT_CNT_EN
  , input  logic                   cnt_clr,
  output logic [CH_NUM*CNT_W-1:0]  grant_cnt
`endif
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q;
  logic [CH_NUM-1:0] gnt;
  logic [SEL_W-1:0]  idx;
  logic              any;
  logic              load_ok;
  logic              xfer;

  assign out_valid = (state_q == FULL);
  assign load_ok   = (state_q == EMPTY) || (out_valid && out_ready);
  assign busy      = out_valid | (|in_valid);

  // Holding off grants during reset keeps the handshake silent while the word is dropped.
  rr_arbiter_4 u_arb (
    .req (in_valid),
    .ptr (ptr_q),
    .en  (load_ok && rst_n),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign in_ready = gnt;
  assign xfer     = any && load_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (out_ready && !xfer) state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr_q    <= '0;
    end else if (xfer) begin
      out_data <= in_data[int'(idx)*DATA_W +: DATA_W];
      out_sel  <= idx;
      ptr_q    <= next_ptr(idx);
    end
  end

`ifdef MUX4_GRANT_CNT_EN
  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (!rst_n || cnt_clr) begin
        grant_cnt[i*CNT_W +: CNT_W] <= '0;
      end else if (in_valid[i] && in_ready[i] &&
                   (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Directed table-driven bench for mux_4to1_rr; counter checks build when MUX4_GRANT_CNT_EN is defined.
module tb_mux_4to1_rr;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        busy;
`ifdef MUX4_GRANT_CNT_EN
  logic        cnt_clr;
  logic [4*CNT_W-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mux_4to1_rr #(
    .DATA_W (DATA_W)
`ifdef MUX4_GRANT_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .busy      (busy)
`ifdef MUX4_GRANT_CNT_EN
    , .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [7:0]  exp_data;
  } vec_t;

  localparam logic [31:0] DA = 32'hA3A2A1A0;
  localparam logic [31:0] DB = 32'hA35CA1A0;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, check grants before the rising edge, registers 1 ns after it.
  task automatic applyStimulus(input string name, input vec_t v);
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = v.data;
    out_ready = v.ordy;
    #1;
    checkOutput({name, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    checkOutput({name, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
    checkOutput({name, " out_sel"}, 32'(out_sel), 32'(v.exp_sel));
    checkOutput({name, " out_data"}, 32'(out_data), 32'(v.exp_data));
    checkOutput({name, " busy"}, 32'(busy), 32'(v.exp_ov | (|v.iv)));
  endtask

  initial begin
    // Round robin over all four lanes, one word per cycle
    vecs[0]  = '{4'b1111, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    vecs[1]  = '{4'b1111, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    vecs[2]  = '{4'b1111, DA, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    vecs[3]  = '{4'b1111, DA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    vecs[4]  = '{4'b1111, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    vecs[5]  = '{4'b0000, DA, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0};
    // Lane 2 word then five stalled cycles with every lane requesting
    vecs[6]  = '{4'b0100, DB, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h5C};
    vecs[7]  = '{4'b1111, DB, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h5C};
    vecs[8]  = '{4'b1111, DB, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h5C};
    vecs[9]  = '{4'b1111, DB, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h5C};
    vecs[10] = '{4'b1111, DB, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h5C};
    vecs[11] = '{4'b1111, DB, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h5C};
    vecs[12] = '{4'b0000, DB, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h5C};
    // Pointer now 3: lane 1 is reached by skipping, then lane 0 by wrapping
    vecs[13] = '{4'b0010, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    vecs[14] = '{4'b0001, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    vecs[15] = '{4'b0000, DA, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0};

    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = DA;
    out_ready = 1'b1;
`ifdef MUX4_GRANT_CNT_EN
    cnt_clr   = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset out_sel", 32'(out_sel), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Load a word from a nonzero pointer, then reset while it is stalled
    applyStimulus("pre_reset", '{4'b0001, DA, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA0});
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    #1;
    checkOutput("midreset ptr grant", 32'(in_ready), 32'b0001);
    in_valid = 4'b0000;

`ifdef MUX4_GRANT_CNT_EN
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("cnt%0d", i), '{4'b0010, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    end
    checkOutput("cnt saturate", 32'(grant_cnt), 32'h0C);
    cnt_clr = 1'b1;
    applyStimulus("cnt_clr", '{4'b0010, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    checkOutput("cnt clear wins", 32'(grant_cnt), 32'h00);
    cnt_clr = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
